// File: rtl/rob_superscalar.sv
// Reorder buffer: tracks in-flight RV32 instructions and retires up to COMMIT_W per cycle in order.
// Latency: writeback -> earliest commit 1 cycle; commit -> registered rf/mem/bp/redirect outputs 1 cycle.
// Backpressure: alloc_ready drops at full occupancy; head store waits on mem_ready; rdy low freezes all state.
module rob_superscalar #(
  parameter int DEPTH    = 16,
  parameter int ID_W     = 4,
  parameter int XLEN     = 32,
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2,
  parameter int Q_PORTS  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [1:0]                 alloc_kind,
  input  logic [4:0]                 alloc_rd,
  input  logic                       alloc_pred,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic                       alloc_c,
  output logic [ID_W-1:0]            alloc_id,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*ID_W-1:0]   wb_id,
  input  logic [WB_PORTS*XLEN-1:0]   wb_val,
  input  logic [WB_PORTS*XLEN-1:0]   wb_addr,
  input  logic [Q_PORTS*ID_W-1:0]    q_id,
  output logic [Q_PORTS-1:0]         q_ready,
  output logic [Q_PORTS*XLEN-1:0]    q_val,
  input  logic                       mem_ready,
  output logic [COMMIT_W-1:0]        rf_we,
  output logic [COMMIT_W*5-1:0]      rf_rd,
  output logic [COMMIT_W*XLEN-1:0]   rf_val,
  output logic                       mem_en,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_data,
  output logic                       bp_en,
  output logic [XLEN-1:0]            bp_pc,
  output logic                       bp_taken,
  output logic                       bp_correct,
  output logic                       redirect,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [ID_W-1:0]            head_id
);
  localparam logic [1:0] K_REG = 2'd0, K_BR = 2'd1, K_ST = 2'd2, K_JALR = 2'd3;

  logic [DEPTH-1:0] ent_valid, ent_ready, valid_n, ready_n, retire_mask;
  logic [1:0]       ent_kind [DEPTH];
  logic [4:0]       ent_rd   [DEPTH];
  logic             ent_pred [DEPTH];
  logic             ent_c    [DEPTH];
  logic [XLEN-1:0]  ent_pc   [DEPTH];
  logic [XLEN-1:0]  ent_val  [DEPTH];
  logic [XLEN-1:0]  ent_addr [DEPTH];

  logic [ID_W-1:0]  head, tail, head_n, tail_n, idx;
  logic [ID_W:0]    count, count_n, ret_cnt;
  logic             alloc_fire, squash, stop, ok;

  logic [COMMIT_W-1:0]      c_rf_we;
  logic [COMMIT_W*5-1:0]    c_rf_rd;
  logic [COMMIT_W*XLEN-1:0] c_rf_val;
  logic                     c_mem_en, c_bp_en, c_bp_taken, c_bp_correct;
  logic [XLEN-1:0]          c_mem_addr, c_mem_data, c_bp_pc, c_redirect_pc;

  assign alloc_ready = count < (ID_W+1)'(DEPTH);
  assign alloc_id    = tail;
  assign head_id     = head;
  assign alloc_fire  = alloc_valid && alloc_ready && rdy;

  // Operand query reads stored state only; a same-cycle writeback shows up next cycle.
  always_comb begin
    for (int q = 0; q < Q_PORTS; q++) begin
      q_ready[q] = ent_valid[q_id[q*ID_W +: ID_W]] && ent_ready[q_id[q*ID_W +: ID_W]];
      q_val[q*XLEN +: XLEN] = q_ready[q] ? ent_val[q_id[q*ID_W +: ID_W]] : '0;
    end
  end

  // Commit scan from head: stop at the first non-retirable slot or after a branch/store/jalr.
  always_comb begin
    stop = 1'b0; ok = 1'b0; idx = head; ret_cnt = '0; squash = 1'b0; retire_mask = '0;
    c_rf_we = '0; c_rf_rd = '0; c_rf_val = '0;
    c_mem_en = 1'b0; c_mem_addr = '0; c_mem_data = '0;
    c_bp_en = 1'b0; c_bp_pc = '0; c_bp_taken = 1'b0; c_bp_correct = 1'b0; c_redirect_pc = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx = head + ID_W'(k);
      ok  = !stop && ((ID_W+1)'(k) < count) && ent_valid[idx] && ent_ready[idx] &&
            (ent_kind[idx] != K_ST || mem_ready);
      if (ok) begin
        retire_mask[idx] = 1'b1;
        ret_cnt = ret_cnt + (ID_W+1)'(1);
        case (ent_kind[idx])
          K_REG: begin
            c_rf_we[k] = 1'b1;
            c_rf_rd[k*5 +: 5] = ent_rd[idx];
            c_rf_val[k*XLEN +: XLEN] = ent_val[idx];
          end
          K_BR: begin
            c_bp_en = 1'b1;
            c_bp_pc = ent_pc[idx];
            c_bp_taken = ent_val[idx][0];
            c_bp_correct = (ent_val[idx][0] == ent_pred[idx]);
            if (!c_bp_correct) begin
              squash = 1'b1;
              c_redirect_pc = ent_val[idx][0] ? ent_addr[idx]
                            : ent_pc[idx] + (ent_c[idx] ? XLEN'(2) : XLEN'(4));
            end
            stop = 1'b1;
          end
          K_ST: begin
            c_mem_en = 1'b1;
            c_mem_addr = ent_addr[idx];
            c_mem_data = ent_val[idx];
            stop = 1'b1;
          end
          default: begin
            c_rf_we[k] = 1'b1;
            c_rf_rd[k*5 +: 5] = ent_rd[idx];
            c_rf_val[k*XLEN +: XLEN] = ent_val[idx];
            squash = 1'b1;
            c_redirect_pc = ent_addr[idx];
            stop = 1'b1;
          end
        endcase
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Next valid/ready bits and pointers: writeback, then retirement, then squash or allocation.
  always_comb begin
    valid_n = ent_valid & ~retire_mask;
    ready_n = ent_ready;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] && ent_valid[wb_id[p*ID_W +: ID_W]])
        ready_n[wb_id[p*ID_W +: ID_W]] = 1'b1;
    head_n = head + ret_cnt[ID_W-1:0];
    if (squash) begin
      valid_n = '0;
      ready_n = '0;
      tail_n  = head_n;
      count_n = '0;
    end else begin
      if (alloc_fire) begin
        valid_n[tail] = 1'b1;
        ready_n[tail] = 1'b0;
      end
      tail_n  = tail + ID_W'(alloc_fire);
      count_n = count + (ID_W+1)'(alloc_fire) - ret_cnt;
    end
  end

  // Control state: pointers, occupancy and per-entry valid/ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0; tail <= '0; count <= '0;
      ent_valid <= '0; ent_ready <= '0;
    end else if (rdy) begin
      head <= head_n; tail <= tail_n; count <= count_n;
      ent_valid <= valid_n; ent_ready <= ready_n;
    end
  end

  // Entry payload: allocation fields, then writeback results (highest port wins on the same id).
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && ent_valid[wb_id[p*ID_W +: ID_W]]) begin
          ent_addr[wb_id[p*ID_W +: ID_W]] <= wb_addr[p*XLEN +: XLEN];
          if (ent_kind[wb_id[p*ID_W +: ID_W]] != K_JALR)
            ent_val[wb_id[p*ID_W +: ID_W]] <= wb_val[p*XLEN +: XLEN];
        end
      end
      if (alloc_fire && !squash) begin
        ent_kind[tail] <= alloc_kind;
        ent_rd[tail]   <= alloc_rd;
        ent_pred[tail] <= alloc_pred;
        ent_pc[tail]   <= alloc_pc;
        ent_c[tail]    <= alloc_c;
        ent_val[tail]  <= alloc_pc + (alloc_c ? XLEN'(2) : XLEN'(4));
      end
    end
  end

  // Registered commit outputs: pulses clear when frozen, payloads hold until the next retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= '0; rf_rd <= '0; rf_val <= '0;
      mem_en <= 1'b0; mem_addr <= '0; mem_data <= '0;
      bp_en <= 1'b0; bp_pc <= '0; bp_taken <= 1'b0; bp_correct <= 1'b0;
      redirect <= 1'b0; redirect_pc <= '0;
    end else if (!rdy) begin
      rf_we <= '0; mem_en <= 1'b0; bp_en <= 1'b0; redirect <= 1'b0;
    end else begin
      rf_we <= c_rf_we; mem_en <= c_mem_en; bp_en <= c_bp_en; redirect <= squash;
      for (int k = 0; k < COMMIT_W; k++) begin
        if (c_rf_we[k]) begin
          rf_rd[k*5 +: 5] <= c_rf_rd[k*5 +: 5];
          rf_val[k*XLEN +: XLEN] <= c_rf_val[k*XLEN +: XLEN];
        end
      end
      if (c_mem_en) begin
        mem_addr <= c_mem_addr;
        mem_data <= c_mem_data;
      end
      if (c_bp_en) begin
        bp_pc <= c_bp_pc; bp_taken <= c_bp_taken; bp_correct <= c_bp_correct;
      end
      if (squash) redirect_pc <= c_redirect_pc;
    end
  end
endmodule

// File: tb/tb_rob_superscalar.sv
// Bench for rob_superscalar: scoreboard of expected register commits plus per-scenario checks.
module tb_rob_superscalar;
  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  logic        alloc_valid = 1'b0, alloc_ready, alloc_pred = 1'b0, alloc_c = 1'b0;
  logic [1:0]  alloc_kind = '0;
  logic [4:0]  alloc_rd = '0;
  logic [31:0] alloc_pc = '0;
  logic [3:0]  alloc_id, head_id;
  logic [1:0]  wb_valid = '0;
  logic [7:0]  wb_id = '0;
  logic [63:0] wb_val = '0, wb_addr = '0;
  logic [7:0]  q_id = '0;
  logic [1:0]  q_ready;
  logic [63:0] q_val;
  logic        mem_ready = 1'b1;
  logic [1:0]  rf_we;
  logic [9:0]  rf_rd;
  logic [63:0] rf_val;
  logic        mem_en, bp_en, bp_taken, bp_correct, redirect;
  logic [31:0] mem_addr, mem_data, bp_pc, redirect_pc;

  int total = 0, bad = 0;
  logic [36:0] sb [$];     // {rd, val} in expected retirement order
  logic        sb_on = 1'b0;
  logic [3:0]  m_tail = '0;

  always #5 clk = ~clk;

  rob_superscalar dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
    .alloc_rd(alloc_rd), .alloc_pred(alloc_pred), .alloc_pc(alloc_pc), .alloc_c(alloc_c),
    .alloc_id(alloc_id), .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .wb_addr(wb_addr),
    .q_id(q_id), .q_ready(q_ready), .q_val(q_val), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_val(rf_val), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .bp_en(bp_en), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .bp_correct(bp_correct), .redirect(redirect), .redirect_pc(redirect_pc), .head_id(head_id)
  );

  // Scoreboard: every RF write pulse, oldest slot first, must match the next expected commit.
  always @(negedge clk) begin
    if (rst_n && sb_on) begin
      for (int k = 0; k < 2; k++) begin
        if (rf_we[k]) begin
          total = total + 1;
          if (sb.size() == 0) begin
            bad = bad + 1;
            $display("FAIL commit_unexpected slot=%0d got rd=%0d val=%h required no commit",
                     k, rf_rd[k*5 +: 5], rf_val[k*32 +: 32]);
          end else begin
            logic [36:0] e;
            e = sb.pop_front();
            if ({rf_rd[k*5 +: 5], rf_val[k*32 +: 32]} !== e) begin
              bad = bad + 1;
              $display("FAIL commit_order slot=%0d got rd=%0d val=%h required rd=%0d val=%h",
                       k, rf_rd[k*5 +: 5], rf_val[k*32 +: 32], e[36:32], e[31:0]);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [1:0] kind, input logic [4:0] rd, input logic pred,
                          input logic [31:0] pc, input logic c, output logic [3:0] id);
    alloc_valid = 1'b1; alloc_kind = kind; alloc_rd = rd; alloc_pred = pred;
    alloc_pc = pc; alloc_c = c;
    id = alloc_id;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input int port, input logic [3:0] id, input logic [31:0] val,
                       input logic [31:0] addr);
    wb_valid = '0;
    wb_valid[port] = 1'b1;
    wb_id[port*4 +: 4] = id;
    wb_val[port*32 +: 32] = val;
    wb_addr[port*32 +: 32] = addr;
    tick();
    wb_valid = '0;
  endtask

  task automatic test_reset();
    logic [3:0] id;
    #3;
    total++; if (alloc_ready !== 1'b1 || head_id !== 4'd0 || alloc_id !== 4'd0) begin
      bad++; $display("FAIL reset_state got ready=%b head=%0d tail=%0d required 1 0 0",
                      alloc_ready, head_id, alloc_id); end
    total++; if (rf_we !== 2'b00 || mem_en !== 1'b0 || redirect !== 1'b0 || bp_en !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got rf_we=%b mem_en=%b redirect=%b bp_en=%b required 0",
                      rf_we, mem_en, redirect, bp_en); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    // mid-operation: five entries, the two oldest complete, reset lands on the commit pulse
    for (int i = 0; i < 5; i++) do_alloc(2'd0, 5'(i + 1), 1'b0, 32'h0, 1'b0, id);
    total++; if (alloc_id !== 4'd5) begin
      bad++; $display("FAIL reset_pre_tail got %0d required 5", alloc_id); end
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_val = {32'h2, 32'h1};
    tick();
    wb_valid = '0;
    tick();
    total++; if (rf_we !== 2'b11) begin
      bad++; $display("FAIL reset_pre_commit got rf_we=%b required 11", rf_we); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (head_id !== 4'd0 || alloc_id !== 4'd0 || rf_we !== 2'b00 || alloc_ready !== 1'b1) begin
      bad++; $display("FAIL reset_async got head=%0d tail=%0d rf_we=%b ready=%b required 0 0 00 1",
                      head_id, alloc_id, rf_we, alloc_ready); end
    @(negedge clk); rst_n = 1'b1;
    m_tail = '0;
    tick();
  endtask

  task automatic test_fill();
    logic [3:0] id;
    int id_bad = 0;
    sb_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (alloc_ready !== 1'b1) id_bad++;
      do_alloc(2'd0, 5'(i), 1'b0, 32'h0, 1'b0, id);
      if (id !== m_tail) id_bad++;
      m_tail = m_tail + 4'd1;
      sb.push_back({5'(i), 32'h100 + 32'(i)});
    end
    total++; if (id_bad != 0) begin
      bad++; $display("FAIL fill_ids got %0d bad ids/ready during fill required 0", id_bad); end
    total++; if (alloc_ready !== 1'b0) begin
      bad++; $display("FAIL fill_full got alloc_ready=%b required 0", alloc_ready); end
    do_alloc(2'd0, 5'd31, 1'b0, 32'h0, 1'b0, id);
    total++; if (alloc_id !== 4'd0 || alloc_ready !== 1'b0) begin
      bad++; $display("FAIL fill_17th got tail=%0d ready=%b required 0 0", alloc_id, alloc_ready); end
    for (int i = 0; i < 16; i++) do_wb(i % 2, 4'(i), 32'h100 + 32'(i), 32'h0);
    repeat (4) tick();
    total++; if (sb.size() != 0 || alloc_ready !== 1'b1 || head_id !== 4'd0) begin
      bad++; $display("FAIL fill_drain got pending=%0d ready=%b head=%0d required 0 1 0",
                      sb.size(), alloc_ready, head_id); end
  endtask

  task automatic test_dual_commit();
    logic [3:0] a, b;
    do_alloc(2'd0, 5'd3, 1'b0, 32'h0, 1'b0, a);
    do_alloc(2'd0, 5'd4, 1'b0, 32'h0, 1'b0, b);
    m_tail = m_tail + 4'd2;
    sb.push_back({5'd3, 32'h11});
    sb.push_back({5'd4, 32'h22});
    wb_valid = 2'b11; wb_id = {b, a}; wb_val = {32'h22, 32'h11};
    q_id = {b, a};
    total++; if (q_ready !== 2'b00) begin
      bad++; $display("FAIL query_no_bypass got q_ready=%b required 00", q_ready); end
    tick();
    wb_valid = '0;
    total++; if (q_ready !== 2'b11 || q_val !== {32'h22, 32'h11}) begin
      bad++; $display("FAIL query_ready got q_ready=%b q_val=%h required 11 %h",
                      q_ready, q_val, {32'h22, 32'h11}); end
    tick();
    total++; if (rf_we !== 2'b11 || rf_rd !== {5'd4, 5'd3} || rf_val !== {32'h22, 32'h11}) begin
      bad++; $display("FAIL dual_commit got we=%b rd=%h val=%h required 11 %h %h",
                      rf_we, rf_rd, rf_val, {5'd4, 5'd3}, {32'h22, 32'h11}); end
    tick();
  endtask

  task automatic test_store_stall();
    logic [3:0] s;
    int pulses = 0;
    logic [31:0] got_a = '0, got_d = '0;
    mem_ready = 1'b0;
    do_alloc(2'd2, 5'd0, 1'b0, 32'h0, 1'b0, s);
    m_tail = m_tail + 4'd1;
    do_wb(0, s, 32'h41, 32'h30000);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_en) pulses++;
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_en) begin pulses++; got_a = mem_addr; got_d = mem_data; end
    end
    total++; if (pulses != 1) begin
      bad++; $display("FAIL store_pulses got %0d required 1", pulses); end
    total++; if (got_a !== 32'h30000 || got_d !== 32'h41) begin
      bad++; $display("FAIL store_data got addr=%h data=%h required 00030000 00000041",
                      got_a, got_d); end
  endtask

  task automatic test_mispredict();
    logic [3:0] br, y0, y1, y2;
    do_alloc(2'd1, 5'd0, 1'b1, 32'h100, 1'b1, br);
    do_alloc(2'd0, 5'd7, 1'b0, 32'h0, 1'b0, y0);
    do_alloc(2'd0, 5'd8, 1'b0, 32'h0, 1'b0, y1);
    do_alloc(2'd0, 5'd9, 1'b0, 32'h0, 1'b0, y2);
    // younger y0 completes alongside the branch and must still be squashed
    wb_valid = 2'b11; wb_id = {y0, br}; wb_val = {32'h77, 32'h0}; wb_addr = {32'h0, 32'h200};
    tick();
    wb_valid = '0;
    tick();
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h102) begin
      bad++; $display("FAIL mispredict_redirect got %b pc=%h required 1 00000102",
                      redirect, redirect_pc); end
    total++; if (bp_en !== 1'b1 || bp_correct !== 1'b0 || bp_taken !== 1'b0 || bp_pc !== 32'h100) begin
      bad++; $display("FAIL mispredict_bp got en=%b correct=%b taken=%b pc=%h required 1 0 0 00000100",
                      bp_en, bp_correct, bp_taken, bp_pc); end
    m_tail = br + 4'd1;
    total++; if (alloc_id !== m_tail || head_id !== m_tail || alloc_ready !== 1'b1) begin
      bad++; $display("FAIL mispredict_squash got tail=%0d head=%0d ready=%b required %0d %0d 1",
                      alloc_id, head_id, alloc_ready, m_tail, m_tail); end
    do_wb(1, y1, 32'h55, 32'h0);
    q_id = {y2, y1};
    #1;
    total++; if (q_ready !== 2'b00 || redirect !== 1'b0) begin
      bad++; $display("FAIL mispredict_stale_wb got q_ready=%b redirect=%b required 00 0",
                      q_ready, redirect); end
  endtask

  task automatic test_wraparound();
    logic [3:0] id;
    int id_bad = 0;
    for (int i = 0; i < 40; i++) begin
      do_alloc(2'd0, 5'((i % 31) + 1), 1'b0, 32'h0, 1'b0, id);
      if (id !== m_tail) id_bad++;
      m_tail = m_tail + 4'd1;
      sb.push_back({5'((i % 31) + 1), 32'h1000 + 32'(i)});
      wb_valid = '0;
      wb_valid[i % 2] = 1'b1;
      wb_id[(i % 2)*4 +: 4] = id;
      wb_val[(i % 2)*32 +: 32] = 32'h1000 + 32'(i);
    end
    tick();
    wb_valid = '0;
    repeat (4) tick();
    total++; if (id_bad != 0) begin
      bad++; $display("FAIL wrap_ids got %0d wrong ids required 0", id_bad); end
    total++; if (sb.size() != 0 || head_id !== m_tail || alloc_ready !== 1'b1) begin
      bad++; $display("FAIL wrap_drain got pending=%0d head=%0d required 0 %0d",
                      sb.size(), head_id, m_tail); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_dual_commit();
    test_store_stall();
    test_mispredict();
    test_wraparound();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
